global_mem_responder: RTL and testbench

- Memory-side responder for the cluster's global memory port; the target end of the PE cluster's single-word read/write request interface.
- Samples a level-held read or write request and services it from an internal word-addressed RAM after a programmable latency.
- Returns a one-cycle ack, plus read data for reads.
- Flags illegal requests with an error indication instead of corrupting memory.

---
 rtl/global_mem_responder_pkg.sv | 19 +
 rtl/global_mem_responder_word_ram.sv | 20 ++
 rtl/global_mem_responder.sv | 105 ++++++++++
 tb/tb_global_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/global_mem_responder_pkg.sv
// Shared types and constants for the global memory responder.
package global_mem_responder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/global_mem_responder_word_ram.sv
// Single-port word RAM with registered read data (read-before-write).
module word_ram
  import global_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             addr,
  input  logic [WORD_BYTES*8-1:0]   wdata,
  output logic [WORD_BYTES*8-1:0]   rdata
);
  logic [WORD_BYTES*8-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end
endmodule

// File: rtl/global_mem_responder.sv
// Memory-side target of the cluster's global memory port: one outstanding
// request, fixed per-op latency, single-cycle ack with error flag.
module global_mem_responder
  import global_mem_responder_pkg::*;
#(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] global_mem_address,
  input  logic [31:0] global_mem_write_data,
  input  logic        global_mem_write,
  input  logic        global_mem_read,
  output logic [31:0] global_mem_read_data,
  output logic        global_mem_ack,
  output logic        global_mem_err,
  output logic        busy
);
  localparam int               AW     = clog2(DEPTH);
  localparam logic [32:0]      SPAN   = 33'(DEPTH) * 33'(WORD_BYTES);
  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WRITE_LATENCY);

  state_t           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt, w_lat;
  logic [AW-1:0]    r_idx, w_in_idx, w_ram_addr;
  logic [31:0]      r_wdata, r_rdata, w_ram_rdata, w_ack_data, w_off;
  logic             r_write, r_illegal;
  logic             w_req, w_illegal, w_accept, w_ram_we, w_rd_ack;

  assign w_req     = global_mem_read | global_mem_write;
  assign w_off     = global_mem_address - BASE_ADDR;
  assign w_in_idx  = w_off[AW+1:2];
  // Offset compare is unsigned, so addresses below BASE_ADDR wrap high and fail too.
  assign w_illegal = (global_mem_read & global_mem_write) |
                     (global_mem_address[1:0] != 2'b00) |
                     ({1'b0, w_off} >= SPAN);
  assign w_lat     = global_mem_read ? RD_LAT : WR_LAT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_req) begin
        w_accept    = 1'b1;
        w_state_nxt = (w_lat == LAT_W'(1)) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT:    if (r_cnt == LAT_W'(1)) w_state_nxt = ST_ACK;
      ST_ACK:     w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!w_req) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_illegal <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_idx     <= w_in_idx;
        r_wdata   <= global_mem_write_data;
        r_write   <= global_mem_write;
        r_illegal <= w_illegal;
        r_cnt     <= w_lat - LAT_W'(1);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
      if (w_rd_ack) r_rdata <= w_ack_data;
    end
  end

  // RAM reads every cycle; the address presented on the edge into ACK
  // (acceptance edge when LAT==1) determines the data seen during ACK.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_ram_we   = (r_state == ST_ACK) & r_write & ~r_illegal;

  word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  assign w_rd_ack   = (r_state == ST_ACK) & (~r_write | r_illegal);
  assign w_ack_data = r_illegal ? 32'h0 : w_ram_rdata;

  assign global_mem_ack       = (r_state == ST_ACK);
  assign global_mem_err       = (r_state == ST_ACK) & r_illegal;
  assign busy                 = (r_state != ST_IDLE);
  assign global_mem_read_data = w_rd_ack ? w_ack_data : r_rdata;
endmodule

// File: tb/tb_global_mem_responder.sv
// Directed bench for global_mem_responder with a cycle-level reference model.
module tb_global_mem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          RL    = 2;
  localparam int          WL    = 1;

  logic        clk, reset;
  logic [31:0] address, wdata, rdata;
  logic        wr, rd, ack, err, busy;

  int checks = 0, errors = 0, ack_count = 0;

  global_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE),
                         .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .global_mem_address    (address),
    .global_mem_write_data (wdata),
    .global_mem_write      (wr),
    .global_mem_read       (rd),
    .global_mem_read_data  (rdata),
    .global_mem_ack        (ack),
    .global_mem_err        (err),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks edges since acceptance and applies the
  // legality/latency rules directly on plain arithmetic.
  logic [31:0] m_mem [DEPTH];
  bit          m_idle = 1, m_wr, m_ill;
  int          m_since = 0, m_lat = 1, m_idx;
  logic [31:0] m_wd, m_hold = 0;
  bit          e_busy = 0, e_ack = 0, e_err = 0;
  logic [31:0] e_rd = 0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

  always @(negedge clk) begin
    if (!reset) begin
      m_idle = 1; m_since = 0; m_hold = 0;
      e_busy = 0; e_ack = 0; e_err = 0; e_rd = 0;
      chk("outputs_in_reset", {busy, ack, err, rdata}, 35'h0);
    end else begin
      chk("outputs", {busy, ack, err, rdata}, {e_busy, e_ack, e_err, e_rd});
      if (ack) ack_count++;
      if (e_ack && m_wr && !m_ill) m_mem[m_idx] = m_wd;
      if (m_idle) begin
        if (rd || wr) begin
          logic [31:0] off;
          off     = address - BASE;
          m_ill   = (rd && wr) || (address % 4 != 0) || (off >= 32'(DEPTH * 4));
          m_idx   = int'((off / 4) % DEPTH);
          m_wr    = !rd && wr;
          m_wd    = wdata;
          m_lat   = rd ? RL : WL;
          m_idle  = 0;
          m_since = 1;
        end
      end else if (m_since > m_lat) begin
        if (!(rd || wr)) begin m_idle = 1; m_since = 0; end
      end else begin
        m_since++;
      end
      e_busy = !m_idle;
      e_ack  = !m_idle && (m_since == m_lat);
      e_err  = e_ack && m_ill;
      if (e_ack) begin
        if (m_ill)      m_hold = 32'h0;
        else if (!m_wr) m_hold = m_mem[m_idx];
      end
      e_rd = m_hold;
    end
  end

  // Raise a request, wait (bounded) for ack, optionally retarget inputs
  // right after acceptance, hold for extra cycles, then drop.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w,
                        input int hold, input bit chg, input logic [31:0] a2, input logic [31:0] d2,
                        output int lat, output logic [31:0] rv, output bit ev);
    bit got;
    got = 0; lat = 0; rv = 'x; ev = 0;
    @(posedge clk); #1;
    address = a; wdata = d; rd = r; wr = w;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      lat++;
      if (chg && k == 0) begin #1; address = a2; wdata = d2; end
      @(negedge clk);
      if (ack) begin got = 1; rv = rdata; ev = err; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack, want ack for addr %0h", a);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int lat, a0;
    logic [31:0] rv;
    bit ev;
    reset = 0; address = 0; wdata = 0; rd = 0; wr = 0;
    @(negedge clk);
    chk("reset_busy_ack_err_rd", {busy, ack, err, rdata}, 35'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // basic write then read-back
    do_req(32'h10, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, lat, rv, ev);
    chk("wr_latency", lat, 1);
    chk("wr_err", ev, 0);
    do_req(32'h10, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("rd_latency", lat, 2);
    chk("rd_data", rv, 32'hDEAD_BEEF);
    chk("rd_err", ev, 0);

    // back-to-back fill and read-back of 16 words
    a0 = ack_count;
    for (int i = 0; i < 16; i++)
      do_req(32'(i * 4), 32'hA500_0000 | 32'(i), 0, 1, 0, 0, 0, 0, lat, rv, ev);
    for (int i = 0; i < 16; i++) begin
      do_req(32'(i * 4), 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
      chk("b2b_rd", rv, 32'hA500_0000 | 32'(i));
    end
    chk("b2b_ack_count", ack_count - a0, 32);

    // illegal requests
    do_req(32'h2, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("misalign_err", ev, 1);
    chk("misalign_rd", rv, 0);
    do_req(32'h1000, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("range_err", ev, 1);
    chk("range_rd", rv, 0);
    do_req(32'h4, 32'h1111_1111, 1, 1, 0, 0, 0, 0, lat, rv, ev);
    chk("rdwr_err", ev, 1);
    chk("rdwr_rd", rv, 0);
    do_req(32'h0, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("after_illegal_0", rv, 32'hA500_0000);
    do_req(32'h4, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("after_illegal_4", rv, 32'hA500_0001);

    // request held long after ack
    a0 = ack_count;
    do_req(32'h10, 0, 1, 0, 6, 0, 0, 0, lat, rv, ev);
    chk("held_rd", rv, 32'hA500_0004);
    chk("held_single_ack", ack_count - a0, 1);
    do_req(32'h14, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("after_release_latency", lat, 2);

    // reset aborts an in-flight write
    @(posedge clk); #1;
    address = 32'h20; wdata = 32'hBAD0_BAD0; wr = 1;
    @(posedge clk); #1 reset = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    @(posedge clk); #1;
    reset = 1; wr = 0;
    do_req(32'h20, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("abort_old_value", rv, 32'hA500_0008);

    // inputs changed after acceptance are ignored
    do_req(32'h8, 0, 1, 0, 0, 1, 32'hC, 0, lat, rv, ev);
    chk("chg_rd_latched", rv, 32'hA500_0002);
    do_req(32'h3C, 32'h1234_5678, 0, 1, 0, 1, 32'h30, 32'hFFFF_FFFF, lat, rv, ev);
    do_req(32'h3C, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("chg_wr_target", rv, 32'h1234_5678);
    do_req(32'h30, 0, 1, 0, 0, 0, 0, 0, lat, rv, ev);
    chk("chg_wr_other", rv, 32'hA500_000C);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
